tlp_req_sched: RTL

Request scheduler between the AXI decode stage and the PCIe TLP generator. Arbitrates decoded write (MWr) and read (MRd) requests round-robin, gates each on PCIe posted/non-posted flow-control credits, allocates a read tag from a tag pool, and presents one registered request per handshake to the TLP generator. Credit returns and completion-done events from the link side replenish credits and free tags.

---
 rtl/tlp_req_sched_pkg.sv | 45 ++++
 rtl/tlp_req_sched_tag_pool.sv | 66 ++++++
 rtl/tlp_req_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tlp_req_sched_pkg.sv
// Shared types and helpers for the TLP request scheduler.
// Credit arithmetic and the scheduled-request bundle live here.
package tlp_req_sched_pkg;

   localparam int CRED_W     = 12;
   localparam int PKG_ADDR_W = 32;
   localparam int PKG_PAY_W  = 1024;
   localparam int PKG_TAG_W  = 5;

   typedef enum logic {
      RR_W = 1'b0,
      RR_R = 1'b1
   } rr_e;

   typedef struct packed {
      logic                  is_write;
      logic [PKG_ADDR_W-1:0] addr;
      logic [7:0]            length;
      logic [15:0]           bdf;
      logic [PKG_PAY_W-1:0]  data;
      logic [PKG_TAG_W-1:0]  tag;
   } sched_req_t;

   // PD credits are 16 B units, so four DW per credit, rounded up
   function automatic logic [CRED_W-1:0] dw_to_pd(
      input logic [7:0] len_dw
   );
      logic [CRED_W-1:0] ext;
      ext = {{(CRED_W-8){1'b0}}, len_dw};
      return (ext + CRED_W'(3)) >> 2;
   endfunction

   // Net debit and return in one step, clamped at the reset budget
   function automatic logic [CRED_W-1:0] cred_next(
      input logic [CRED_W-1:0] q,
      input logic [CRED_W-1:0] ret,
      input logic [CRED_W-1:0] debit,
      input logic [CRED_W-1:0] lim
   );
      logic [CRED_W:0] s;
      s = {1'b0, q} + {1'b0, ret} - {1'b0, debit};
      return (s > {1'b0, lim}) ? lim : s[CRED_W-1:0];
   endfunction

endpackage

// File: rtl/tlp_req_sched_tag_pool.sv
// Read tag pool: free bitmap with lowest-index allocation.
// Frees land at the clock edge, so a freed tag is offered next cycle.
module tlp_tag_pool #(
   parameter int TAG_COUNT = 32,
   parameter int TAG_W     = $clog2(TAG_COUNT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_i,
   output logic [TAG_W-1:0] alloc_tag_o,
   output logic             avail_o,
   input  logic             free_i,
   input  logic [TAG_W-1:0] free_tag_i,
   output logic [TAG_W:0]   count_o,
   output logic             err_o
);

   logic [TAG_COUNT-1:0] free_q, free_d;
   logic [TAG_W:0]       count_q, count_d;
   logic                 err_q, err_d;
   logic                 free_ok;
   logic [TAG_W-1:0]     alloc_tag;

   // Lowest-index free tag; scanning downward leaves the lowest hit
   always_comb begin
      alloc_tag = '0;
      for (int i = TAG_COUNT-1; i >= 0; i--) begin
         if (free_q[i]) alloc_tag = TAG_W'(i);
      end
   end

   // Next-state for bitmap, in-use count and sticky error
   always_comb begin
      free_d  = free_q;
      count_d = count_q;
      err_d   = err_q;
      free_ok = free_i && !free_q[free_tag_i];
      if (free_i && free_q[free_tag_i]) err_d = 1'b1;
      if (free_ok) free_d[free_tag_i] = 1'b1;
      if (alloc_i) free_d[alloc_tag] = 1'b0;
      unique case ({alloc_i, free_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pool state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         free_q  <= '1;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         free_q  <= free_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign alloc_tag_o = alloc_tag;
   assign avail_o     = |free_q;
   assign count_o     = count_q;
   assign err_o       = err_q;

endmodule

// File: rtl/tlp_req_sched.sv
// Round-robin MWr/MRd scheduler with PCIe credit gating,
// read tag allocation and a single registered output slot.
module tlp_req_sched
   import tlp_req_sched_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 256,
   parameter int CHUNK_MAX_BEATS = 4,
   parameter int TAG_COUNT       = 32,
   parameter int PH_INIT         = 32,
   parameter int PD_INIT         = 256,
   parameter int NPH_INIT        = 32,
   localparam int TAG_W          = $clog2(TAG_COUNT),
   localparam int PAY_W          = DATA_WIDTH*CHUNK_MAX_BEATS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_w_valid,
   output logic                  in_w_ready,
   input  logic [ADDR_WIDTH-1:0] in_w_addr,
   input  logic [7:0]            in_w_length,
   input  logic [15:0]           in_w_bdf,
   input  logic [PAY_W-1:0]      in_w_data,
   input  logic                  in_r_valid,
   output logic                  in_r_ready,
   input  logic [ADDR_WIDTH-1:0] in_r_addr,
   input  logic [7:0]            in_r_length,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_is_write,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [7:0]            out_length,
   output logic [15:0]           out_bdf,
   output logic [PAY_W-1:0]      out_data,
   output logic [TAG_W-1:0]      out_tag,
   input  logic                  cr_ph_ret,
   input  logic [7:0]            cr_pd_ret,
   input  logic                  cr_nph_ret,
   input  logic                  cpl_done_valid,
   input  logic [TAG_W-1:0]      cpl_done_tag,
   output logic [TAG_W:0]        rd_outstanding,
   output logic                  err_tag_free
);

   logic [CRED_W-1:0]     ph_q, pd_q, nph_q;
   logic [CRED_W-1:0]     ph_d, pd_d, nph_d;
   logic [CRED_W-1:0]     pd_need;
   rr_e                   rr_q;
   logic                  w_elig, r_elig, can_load;
   logic                  grant_w, grant_r;
   logic                  tag_avail;
   logic [TAG_W-1:0]      tag_alloc;
   logic                  ov_q, wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [15:0]           bdf_q;
   logic [PAY_W-1:0]      data_q;
   logic [TAG_W-1:0]      tag_q;

   tlp_tag_pool #(
      .TAG_COUNT (TAG_COUNT),
      .TAG_W     (TAG_W)
   ) u_pool (
      .clk         (clk),
      .rst         (rst),
      .alloc_i     (grant_r),
      .alloc_tag_o (tag_alloc),
      .avail_o     (tag_avail),
      .free_i      (cpl_done_valid),
      .free_tag_i  (cpl_done_tag),
      .count_o     (rd_outstanding),
      .err_o       (err_tag_free)
   );

   // Eligibility and round-robin grant into the output slot
   always_comb begin
      pd_need  = dw_to_pd(in_w_length);
      w_elig   = in_w_valid && (ph_q != '0) && (pd_q >= pd_need);
      r_elig   = in_r_valid && (nph_q != '0) && tag_avail;
      can_load = !ov_q || out_ready;
      grant_w  = can_load && w_elig && (!r_elig || rr_q == RR_W);
      grant_r  = can_load && r_elig && (!w_elig || rr_q == RR_R);
   end

   // Credit next-state: debit on grant, return from link side
   always_comb begin
      ph_d  = cred_next(ph_q, CRED_W'(cr_ph_ret),
                        CRED_W'(grant_w), CRED_W'(PH_INIT));
      pd_d  = cred_next(pd_q, CRED_W'(cr_pd_ret),
                        grant_w ? pd_need : '0, CRED_W'(PD_INIT));
      nph_d = cred_next(nph_q, CRED_W'(cr_nph_ret),
                        CRED_W'(grant_r), CRED_W'(NPH_INIT));
   end

   // Credit counters
   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q  <= CRED_W'(PH_INIT);
         pd_q  <= CRED_W'(PD_INIT);
         nph_q <= CRED_W'(NPH_INIT);
      end else begin
         ph_q  <= ph_d;
         pd_q  <= pd_d;
         nph_q <= nph_d;
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         ov_q   <= 1'b0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         len_q  <= '0;
         bdf_q  <= '0;
         data_q <= '0;
         tag_q  <= '0;
         rr_q   <= RR_W;
      end else if (grant_w) begin
         ov_q   <= 1'b1;
         wr_q   <= 1'b1;
         addr_q <= in_w_addr;
         len_q  <= in_w_length;
         bdf_q  <= in_w_bdf;
         data_q <= in_w_data;
         tag_q  <= '0;
         rr_q   <= RR_R;
      end else if (grant_r) begin
         ov_q   <= 1'b1;
         wr_q   <= 1'b0;
         addr_q <= in_r_addr;
         len_q  <= in_r_length;
         bdf_q  <= '0;
         data_q <= '0;
         tag_q  <= tag_alloc;
         rr_q   <= RR_W;
      end else if (out_ready) begin
         ov_q   <= 1'b0;
      end
   end

   assign in_w_ready   = grant_w;
   assign in_r_ready   = grant_r;
   assign out_valid    = ov_q;
   assign out_is_write = wr_q;
   assign out_addr     = addr_q;
   assign out_length   = len_q;
   assign out_bdf      = bdf_q;
   assign out_data     = data_q;
   assign out_tag      = tag_q;

endmodule
